// File: rtl/cpu_core.sv
// Single-cycle 32-bit MIPS-subset core with private imem/dmem and host load ports.
// Define CPU_MUL_EN to implement MUL (funct 0x18); otherwise it executes as NOP.
module cpu_regfile (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] reg_array [0:31];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < 32; i++) reg_array[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            reg_array[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : reg_array[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : reg_array[raddr2];
endmodule

module cpu_core #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        enable,
    input  logic [31:0] addr_ext,
    input  logic        wen_ext,
    input  logic        ren_ext,
    input  logic [31:0] wdata_ext,
    output logic [31:0] rdata_ext,
    input  logic [31:0] addr_ext_2,
    input  logic        wen_ext_2,
    input  logic        ren_ext_2,
    input  logic [31:0] wdata_ext_2,
    output logic [31:0] rdata_ext_2
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_STOP  = 6'h3E;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
`ifdef CPU_MUL_EN
    localparam logic [5:0] F_MUL = 6'h18;
`endif

    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] instruction;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] sext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ea;
    logic [31:0] ld_data;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        reg_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        mem_we;
    logic        run;

    assign instruction = imem[pc[IW+1:2]];
    assign opcode      = instruction[31:26];
    assign rs          = instruction[25:21];
    assign rt          = instruction[20:16];
    assign rd          = instruction[15:11];
    assign funct       = instruction[5:0];
    assign sext        = {{16{instruction[15]}}, instruction[15:0]};

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], instruction[25:0], 2'b00};
    assign ea        = rs_val + sext;
    assign ld_data   = dmem[ea[DW+1:2]];
    // Reset blocks core stores even if enable is already high.
    assign run       = enable & arst_n;

    cpu_regfile register_file (
        .clk    (clk),
        .arst_n (arst_n),
        .we     (reg_we & run),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val)
    );

    always_comb begin
        pc_next = pc_plus4;
        reg_we  = 1'b0;
        wr_addr = rd;
        wr_data = '0;
        mem_we  = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                reg_we = 1'b1;
                unique case (funct)
                    F_ADD: wr_data = rs_val + rt_val;
                    F_SUB: wr_data = rs_val - rt_val;
                    F_AND: wr_data = rs_val & rt_val;
                    F_OR:  wr_data = rs_val | rt_val;
                    F_SLT: wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
`ifdef CPU_MUL_EN
                    F_MUL: wr_data = rs_val * rt_val;
`endif
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                wr_addr = rt;
                wr_data = ea;
            end
            OP_LW: begin
                reg_we  = 1'b1;
                wr_addr = rt;
                wr_data = ld_data;
            end
            OP_SW:   mem_we = 1'b1;
            OP_BEQ:  if (rs_val == rt_val) pc_next = br_target;
            OP_J:    pc_next = j_target;
            OP_STOP: pc_next = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) pc <= '0;
        else if (enable) pc <= pc_next;
    end

    always_ff @(posedge clk) begin
        if (!enable && wen_ext) imem[addr_ext[IW+1:2]] <= wdata_ext;
    end

    always_ff @(posedge clk) begin
        if (run && mem_we) dmem[ea[DW+1:2]] <= rt_val;
        else if (!enable && wen_ext_2) dmem[addr_ext_2[DW+1:2]] <= wdata_ext_2;
    end

    assign rdata_ext   = (!enable && ren_ext)   ? imem[addr_ext[IW+1:2]]   : '0;
    assign rdata_ext_2 = (!enable && ren_ext_2) ? dmem[addr_ext_2[DW+1:2]] : '0;

    logic unused_ext;
    assign unused_ext = ^{addr_ext[31:IW+2], addr_ext[1:0],
                          addr_ext_2[31:DW+2], addr_ext_2[1:0]};
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: host-port vector table plus program runs checked via
// a register scoreboard and hierarchical probes.
module tb_cpu_core;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;

    int vectors = 0;
    int miscompares = 0;

    cpu_core dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          dm;
        bit          wen;
        bit          ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } hvec_t;

    typedef struct {
        string       name;
        int          r;
        logic [31:0] v;
    } rexp_t;

    hvec_t       vt[9];
    logic [31:0] sb_q[$];
    rexp_t       rq[$];
    logic [31:0] prog[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input int r, input int rt_, input int rd,
                                       input logic [5:0] f);
        return {6'd0, 5'(r), 5'(rt_), 5'(rd), 5'd0, f};
    endfunction

    function automatic logic [31:0] ii(input logic [5:0] op, input int r,
                                       input int rt_, input logic [15:0] imm);
        return {op, 5'(r), 5'(rt_), imm};
    endfunction

    function automatic logic [31:0] jj(input int idx);
        return {6'h02, 26'(idx)};
    endfunction

    function automatic logic [31:0] stopw(input logic [1:0] tag);
        return {6'b111110, 24'd0, tag};
    endfunction

    function automatic logic [31:0] reg_of(input int r);
        return dut.register_file.reg_array[r];
    endfunction

    task automatic idle_ports();
        wen_ext = 0; ren_ext = 0; wen_ext_2 = 0; ren_ext_2 = 0;
    endtask

    task automatic host_w(input bit dm, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (dm) begin addr_ext_2 = a; wdata_ext_2 = d; wen_ext_2 = 1; end
        else    begin addr_ext = a;   wdata_ext = d;   wen_ext = 1;   end
        @(negedge clk);
        idle_ports();
    endtask

    task automatic host_r(input bit dm, input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        if (dm) begin addr_ext_2 = a; ren_ext_2 = 1; end
        else    begin addr_ext = a;   ren_ext = 1;   end
        #1;
        d = dm ? rdata_ext_2 : rdata_ext;
        idle_ports();
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 0;
        arst_n = 0;
        @(negedge clk);
        arst_n = 1;
    endtask

    task automatic load_prog();
        enable = 0;
        foreach (prog[i]) host_w(0, 32'(i * 4), prog[i]);
    endtask

    task automatic run_stop(input logic [31:0] sw, input logic [31:0] exp_pc);
        int n = 0;
        while (dut.instruction !== sw && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("halt", dut.instruction, sw);
        repeat (3) @(negedge clk);
        check("pc_hold", dut.pc, exp_pc);
        check("stop_kept", dut.instruction, sw);
    endtask

    task automatic drain_regs();
        rexp_t e;
        while (rq.size() > 0) begin
            e = rq.pop_front();
            check(e.name, reg_of(e.r), e.v);
        end
    endtask

    function automatic int nonzero_regs();
        int c = 0;
        for (int i = 0; i < 32; i++) if (reg_of(i) != 0) c++;
        return c;
    endfunction

    task automatic prog_basic();
        prog = {};
        prog.push_back(ii(6'h08, 0, 16, 16'd7));
        prog.push_back(ii(6'h2B, 0, 16, 16'd0));
        prog.push_back(ii(6'h23, 0, 17, 16'd0));
        prog.push_back(ii(6'h08, 17, 18, 16'd2));
        prog.push_back(rr(18, 16, 19, 6'h20));
        prog.push_back(ii(6'h08, 0, 21, 16'd5));
        prog.push_back(ii(6'h08, 20, 20, 16'd5));
        prog.push_back(ii(6'h08, 21, 21, 16'hFFFF));
        prog.push_back(ii(6'h04, 21, 0, 16'd1));
        prog.push_back(jj(6));
        prog.push_back(stopw(2'b00));
    endtask

    initial begin
        logic [31:0] d;
        vt[0] = '{"imem_wr",   0, 1, 0, 32'h10,   32'hDEADBEEF, 32'h0};
        vt[1] = '{"dmem_wr",   1, 1, 0, 32'hFFC,  32'h12345678, 32'h0};
        vt[2] = '{"imem_rd",   0, 0, 1, 32'h10,   32'h0, 32'hDEADBEEF};
        vt[3] = '{"dmem_rd",   1, 0, 1, 32'hFFC,  32'h0, 32'h12345678};
        vt[4] = '{"imem_wrap", 0, 0, 1, 32'h810,  32'h0, 32'hDEADBEEF};
        vt[5] = '{"dmem_wrap", 1, 0, 1, 32'h1FFC, 32'h0, 32'h12345678};
        vt[6] = '{"imem_ren0", 0, 0, 0, 32'h10,   32'h0, 32'h0};
        vt[7] = '{"dmem_rw",   1, 1, 1, 32'hFFC,  32'hCAFEF00D, 32'h12345678};
        vt[8] = '{"dmem_new",  1, 0, 1, 32'hFFC,  32'h0, 32'hCAFEF00D};

        arst_n = 0; enable = 0;
        addr_ext = 0; wdata_ext = 0; addr_ext_2 = 0; wdata_ext_2 = 0;
        idle_ports();
        #12;
        check("rst_pc", dut.pc, 32'h0);
        check("rst_regs", 32'(nonzero_regs()), 32'h0);
        check("rst_rdata", rdata_ext, 32'h0);
        @(negedge clk);
        arst_n = 1;

        foreach (vt[i]) begin
            @(negedge clk);
            idle_ports();
            if (vt[i].dm) begin
                addr_ext_2 = vt[i].addr; wdata_ext_2 = vt[i].wdata;
                wen_ext_2 = vt[i].wen;   ren_ext_2 = vt[i].ren;
            end else begin
                addr_ext = vt[i].addr; wdata_ext = vt[i].wdata;
                wen_ext = vt[i].wen;   ren_ext = vt[i].ren;
            end
            sb_q.push_back(vt[i].exp);
            #1;
            check(vt[i].name, vt[i].dm ? rdata_ext_2 : rdata_ext, sb_q.pop_front());
        end
        @(negedge clk);
        idle_ports();

        prog_basic();
        load_prog();
        do_reset();
        @(negedge clk) enable = 1;
        rq.push_back('{"r16", 16, 32'h7});
        rq.push_back('{"r17", 17, 32'h7});
        rq.push_back('{"r18", 18, 32'h9});
        rq.push_back('{"r19", 19, 32'h10});
        rq.push_back('{"r20", 20, 32'h19});
        rq.push_back('{"r21", 21, 32'h0});
        run_stop(stopw(2'b00), 32'd40);
        drain_regs();

        host_w(1, 32'h0, 32'h55);
        host_r(1, 32'h0, d);
        check("en_rdata0", d, 32'h0);
        @(negedge clk) enable = 0;
        host_r(1, 32'h0, d);
        check("en_wr_ignored", d, 32'h7);

        host_w(1, 32'h10, 32'h7FFFFFFF);
        prog = {};
        prog.push_back(ii(6'h08, 0, 1, 16'hA));
        prog.push_back(ii(6'h08, 0, 2, 16'h13));
        prog.push_back(rr(1, 2, 9, 6'h18));
        prog.push_back(ii(6'h08, 0, 0, 16'd5));
        prog.push_back(ii(6'h23, 0, 3, 16'h10));
        prog.push_back(ii(6'h08, 3, 3, 16'd1));
        prog.push_back(rr(3, 1, 4, 6'h2A));
        prog.push_back(rr(1, 2, 5, 6'h22));
        prog.push_back(rr(1, 2, 6, 6'h24));
        prog.push_back(rr(1, 2, 7, 6'h25));
        prog.push_back(rr(2, 1, 8, 6'h2A));
        prog.push_back(rr(1, 2, 10, 6'h21));
        prog.push_back(ii(6'h3F, 1, 11, 16'd5));
        prog.push_back(ii(6'h08, 0, 12, 16'h20));
        prog.push_back(ii(6'h2B, 12, 1, 16'hFFFC));
        prog.push_back(ii(6'h23, 0, 13, 16'h1C));
        prog.push_back(ii(6'h08, 0, 14, 16'hFFFE));
        prog.push_back(stopw(2'b01));
        load_prog();
        do_reset();
        @(negedge clk) enable = 1;
`ifdef CPU_MUL_EN
        rq.push_back('{"mul_r9", 9, 32'hBE});
`else
        rq.push_back('{"mul_r9", 9, 32'h0});
`endif
        rq.push_back('{"r0_zero", 0, 32'h0});
        rq.push_back('{"wrap_r3", 3, 32'h80000000});
        rq.push_back('{"slt_neg", 4, 32'h1});
        rq.push_back('{"sub_r5", 5, 32'hFFFFFFF7});
        rq.push_back('{"and_r6", 6, 32'h2});
        rq.push_back('{"or_r7", 7, 32'h1B});
        rq.push_back('{"slt_r8", 8, 32'h0});
        rq.push_back('{"badfunct", 10, 32'h0});
        rq.push_back('{"badop", 11, 32'h0});
        rq.push_back('{"sw_neg", 13, 32'hA});
        rq.push_back('{"addi_neg", 14, 32'hFFFFFFFE});
        run_stop(stopw(2'b01), 32'd68);
        drain_regs();

        @(negedge clk) enable = 0;
        host_w(1, 32'h100, 32'd100);
        host_w(1, 32'h104, 32'd200);
        host_w(1, 32'h108, 32'd300);
        host_w(1, 32'h10C, 32'd299);
        prog = {};
        prog.push_back(ii(6'h08, 0, 1, 16'h100));
        prog.push_back(ii(6'h08, 0, 2, 16'd4));
        prog.push_back(ii(6'h08, 0, 23, 16'd0));
        prog.push_back(ii(6'h23, 1, 4, 16'd0));
        prog.push_back(rr(23, 4, 23, 6'h20));
        prog.push_back(ii(6'h08, 1, 1, 16'd4));
        prog.push_back(ii(6'h08, 2, 2, 16'hFFFF));
        prog.push_back(ii(6'h04, 2, 0, 16'd1));
        prog.push_back(jj(3));
        prog.push_back(stopw(2'b11));
        load_prog();
        do_reset();
        @(negedge clk) enable = 1;
        rq.push_back('{"acc_r23", 23, 32'h383});
        run_stop(stopw(2'b11), 32'd36);
        drain_regs();

        prog_basic();
        load_prog();
        do_reset();
        @(negedge clk) enable = 1;
        repeat (10) @(posedge clk);
        @(negedge clk) enable = 0;
        repeat (20) @(negedge clk);
        check("frz_pc", dut.pc, 32'd24);
        check("frz_r20", reg_of(20), 32'h5);
        check("frz_r21", reg_of(21), 32'h4);
        host_r(0, 32'h18, d);
        check("frz_host", d, prog[6]);
        @(negedge clk) enable = 1;
        run_stop(stopw(2'b00), 32'd40);
        check("resume_r20", reg_of(20), 32'h19);

        do_reset();
        @(negedge clk) enable = 1;
        repeat (8) @(posedge clk);
        #2 arst_n = 0;
        #1;
        check("midrst_pc", dut.pc, 32'h0);
        check("midrst_regs", 32'(nonzero_regs()), 32'h0);
        enable = 0;
        ren_ext = 1;
        addr_ext = 32'h0;
        #1;
        check("rst_host_rd", rdata_ext, prog[0]);
        ren_ext = 0;
        @(negedge clk) arst_n = 1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cpu_core.md
# cpu_core

Single-cycle, 32-bit MIPS-subset processor with its own instruction memory and data memory. Both memories can be loaded and read back by a host through two external ports while the core is disabled. When enabled, the core executes from address 0 until it fetches a STOP instruction, then halts. Top-level compute block of the exercise platform; the register file and the fetched-instruction net are probed hierarchically by verification.

## Interface
- IMEM_WORDS, 512: instruction memory depth in 32-bit words; index is addr[10:2].
- DMEM_WORDS, 1024: data memory depth in 32-bit words; index is addr[11:2].
- clk  in  1  sole clock; all state updates on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = core executes; 0 = core frozen and external ports are active.
- addr_ext / wen_ext / ren_ext / wdata_ext  in  32/1/1/32  host port to instruction memory, byte address.
- rdata_ext  out  32  instruction memory read data.
- addr_ext_2 / wen_ext_2 / ren_ext_2 / wdata_ext_2  in  32/1/1/32  host port to data memory, byte address.
- rdata_ext_2  out  32  data memory read data.
- Required internal names: net `instruction` (32-bit current fetch); register file instance `register_file` with array `reg_array[0:31]`.

## Operation
- Host port, enable=0: wen writes wdata to mem[addr>>2] at the clock edge. ren=1 gives rdata = mem[addr>>2] combinationally; ren=0 gives rdata = 0. With enable=1, host writes are ignored and rdata reads 0.
- Address bits above the memory depth are ignored, so addresses wrap modulo the depth.
- Encodings follow MIPS32:
  - R-type, opcode 0: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, MUL 0x18. MUL writes rd = low 32 bits of rs*rt.
  - ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
  - STOP: opcode 6'b111110. Bits [1:0] are a test tag and are ignored by the core.
- Arithmetic wraps at 32 bits with no overflow trap. ADDI, LW and SW sign-extend imm16. SLT is a signed compare.
- BEQ target = PC+4+(sext(imm)<<2). J target = {PC+4[31:28], imm26, 2'b00}.
- Register 0 always reads 0 and writes to it are discarded.
- Undefined opcodes or functs execute as NOP (PC+4, no writes).
- STOP: PC holds and no writes occur. `instruction` stays equal to STOP until reset.

## Timing
- One instruction per enabled clock.
- PC, register-file and data-memory writes occur at the same rising edge.
- Reads are combinational: imem fetch, register read and dmem load, so LW data is written back in the same cycle.
- enable=0 stalls everything: PC, registers and dmem hold their values.
- Reset clears PC to 0 and all 32 registers to 0. Memory contents are not reset.
- Reset asserted mid-program returns PC to 0 immediately.
- While reset is asserted, rdata_ext and rdata_ext_2 depend only on ren and the memory contents.
- Host write and host read to the same address in the same cycle: read returns the old word, and the new word is visible from the next cycle.

## Configuration
- CPU_MUL_EN defined: MUL (funct 0x18) is implemented as a combinational 32x32 multiply, low 32 bits kept.
- CPU_MUL_EN undefined: funct 0x18 executes as NOP and no multiplier is synthesised.

## Test plan
- Host load/readback: with enable=0, write 0xDEADBEEF to imem byte address 0x10 and 0x12345678 to dmem byte address 0xFFC. Reading both back gives exactly those words; ren=0 gives 0.
- Basic program, loaded then enable=1:
  - ADDI r16=7.
  - SW r16 and LW, then ADDI +2, giving r18=9.
  - ADD r19 = r18+r16 = 0x10.
  - A loop using BEQ leaves r20=0x19.
  - STOP with tag 00 halts with these values and the PC frozen.
- Multiply, CPU_MUL_EN defined: r1=0xA, r2=0x13, MUL r9, STOP tag 01 gives r9=0xBE. With CPU_MUL_EN undefined, r9 stays 0.
- Register-zero and wrap: ADDI r0,r0,5 leaves r0=0. ADDI r3=0x7FFFFFFF then ADDI +1 gives r3=0x80000000.
- Freeze and reset: dropping enable mid-loop holds PC and registers for 20 cycles, and execution resumes correctly. Asserting arst_n low mid-program clears all registers and PC to 0 at once.
- Accumulation loop (sum via LW/ADD/BEQ/J over a dmem array), STOP tag 11: r23=0x383.
